bist_response_checker: RTL and testbench
========================================

Name: bist_response_checker

Overview:
- Sink-side companion to the BIST pattern generator datapath.
- Consumes the 16-bit pattern stream, sample by sample, for a run started by `start`.
- Regenerates the expected ring, Johnson or LFSR sequence locally and compares each sample against it.
- Reports error count, first failing index and pass/fail; optionally compacts the stream into a MISR signature.

Parameters:
- NUM_SAMPLES, 64, number of samples checked per run, including the sync sample; legal range 2..65535.
- CNT_W, 8, width of the saturating error counter.
- IDX_W, 16, width of the sample index and of first_err_idx.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- mode  in  2  pattern select: 00 zero, 01 ring, 10 Johnson, 11 LFSR; sampled on the accepted start.
- sample_valid  in  1  sample qualifier; one sample per cycle max.
- sample  in  16  observed pattern word.
- busy  out  1  high in SYNC and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1: 1 iff err_count==0.
- err_count  out  CNT_W  mismatching samples, saturates at all-ones.
- first_err_idx  out  IDX_W  index (0-based) of first mismatch; all-ones if none.
- signature  out  16  MISR value (BIST_MISR_EN only).

Behaviour:
- Reset, synchronous with rst=1: state=IDLE; busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones, signature=16'h0000, idx=0. rst mid-run aborts the run to the same values.
- Sequence models (pattern update applied per valid sample):
  - ring: rotate left, {e[14:0],e[15]}; canonical seed 16'h0001.
  - Johnson: {e[14:0],~e[15]}; seed 16'h0000.
  - LFSR (Fibonacci, taps 16,14,13,11): {e[14:0], e[15]^e[13]^e[12]^e[10]}; seed 16'hACE1.
  - zero: expected constant 16'h0000.
- FSM states IDLE, SYNC, CHECK, DONE.
- IDLE/DONE, start=1: latch mode; clear err_count, idx and first_err_idx (MISR reset to 0); next state SYNC. DONE outputs hold until then.
- SYNC, sample_valid=1 (index 0): aligns the model to the stream.
  - Sync sample is illegal if: mode 00 and not zero; ring and not one-hot; LFSR and zero. Johnson accepts any value.
  - Legal sync sample: expected <= next(sample).
  - Illegal sync sample: counted as error at index 0 and expected <= next(seed).
  - In both cases idx <= 1, then CHECK.
- CHECK, sample_valid=1: compare sample to expected.
  - On mismatch: err_count++ (saturating); first_err_idx <= idx if still all-ones.
  - Always expected <= next(expected), so resync is never done from a bad sample; then idx++.
  - Sample with idx == NUM_SAMPLES-1 is the last; next state DONE.
- done asserts the cycle after the last sample's clock edge; pass = (err_count==0) registered on the same edge.
- sample_valid=0: no state change; gaps of any length allowed.
- start while busy: ignored. mode changes while busy: ignored. start together with rst: rst wins.
- Samples in IDLE/DONE: ignored.

Optional Feature:
- BIST_MISR_EN defined: 16-bit MISR using the LFSR taps. On every accepted sample (SYNC and CHECK): sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ sample. Cleared on rst and on an accepted start; holds in DONE; `signature` port present.
- Not defined: no MISR logic and no signature port; all other behaviour identical.

Decomposition:
- Package bist_pkg:
  - mode encodings MODE_ZERO/RING/JOHNSON/LFSR;
  - seeds RING_SEED=16'h0001, JOHNSON_SEED=16'h0000, LFSR_SEED=16'hACE1;
  - LFSR tap constants;
  - FSM state encoding.
- Sub-module bist_pattern_model: combinational next-pattern function for (mode, current) plus sync-legality check. It is shared with the generator side to keep both ends bit-exact.

Test Plan:
- Ring, NUM_SAMPLES=16, stream starting 16'h0001 rotating left, continuous valid -> done one cycle after 16th sample, pass=1, err_count=0, first_err_idx=16'hFFFF.
- LFSR from 16'hACE1, 64 samples, sample 10 XOR 16'h0004 -> err_count=1, first_err_idx=10, pass=0; sample 11 (correct) not flagged.
- Johnson sync on 16'h00FF, valid deasserted every other cycle -> pass=1; done timing follows last valid sample.
- Ring sync sample 16'h0003 -> error at index 0, model reseeded to 16'h0002 expected next; a stream continuing 16'h0002,16'h0004.. passes remaining samples, err_count=1.
- Mode 00, all samples 16'hFFFF, CNT_W=8, NUM_SAMPLES=300 -> err_count saturates at 255, first_err_idx=0.
- rst pulsed mid-CHECK -> next cycle IDLE with all outputs at reset values. Subsequent start -> clean run passes. With BIST_MISR_EN: ring 16-sample run gives a repeatable signature matching the bench model.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the BIST pattern generator and response checker.
//   - pattern mode encodings (mode_e)
//   - canonical sequence seeds
//   - LFSR tap mask (x^16 + x^14 + x^13 + x^11) and a one-step helper
//   - response checker FSM state encoding (state_e)
package bist_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO    = 2'b00,
        MODE_RING    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_LFSR    = 2'b11
    } mode_e;

    localparam logic [15:0] RING_SEED    = 16'h0001;
    localparam logic [15:0] JOHNSON_SEED = 16'h0000;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    // Bits 15, 13, 12 and 10 of the current word feed the shifted-in bit.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StCheck,
        StDone
    } state_e;

    // One Fibonacci LFSR step: shift left, shift in the tap parity.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_pattern_model.sv
// bist_pattern_model: combinational reference model of the BIST pattern sequences.
// Shared by generator and checker so both ends stay bit-exact.
// Ports:
//   mode   in  2   pattern select (mode_e)
//   cur    in  16  current pattern word to advance
//   probe  in  16  word whose suitability as a sync sample is judged
//   nxt    out 16  next(cur) for the selected mode
//   seed   out 16  canonical seed for the selected mode
//   legal  out 1   probe is a valid member of the selected sequence
module bist_pattern_model
    import bist_pkg::*;
(
    input  mode_e       mode,
    input  logic [15:0] cur,
    input  logic [15:0] probe,
    output logic [15:0] nxt,
    output logic [15:0] seed,
    output logic        legal
);

    // Kept separate from the legality block: callers may route nxt's operand
    // through legal without forming a combinational loop.
    always_comb begin
        nxt = 16'h0000;
        unique case (mode)
            MODE_ZERO:    nxt = 16'h0000;
            MODE_RING:    nxt = {cur[14:0], cur[15]};
            MODE_JOHNSON: nxt = {cur[14:0], ~cur[15]};
            MODE_LFSR:    nxt = lfsr_step(cur);
            default:      nxt = 16'h0000;
        endcase
    end

    always_comb begin
        seed  = 16'h0000;
        legal = 1'b1;
        unique case (mode)
            MODE_ZERO: begin
                seed  = 16'h0000;
                legal = (probe == 16'h0000);
            end
            MODE_RING: begin
                seed  = RING_SEED;
                // Exactly one bit set.
                legal = (probe != 16'h0000) && ((probe & (probe - 16'd1)) == 16'h0000);
            end
            MODE_JOHNSON: begin
                seed  = JOHNSON_SEED;
                legal = 1'b1;
            end
            MODE_LFSR: begin
                seed  = LFSR_SEED;
                // All-zero is the LFSR lock-up state, never part of the sequence.
                legal = (probe != 16'h0000);
            end
            default: begin
                seed  = 16'h0000;
                legal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bist_response_checker.sv
// bist_response_checker: sink-side BIST checker. Locks a local sequence model to the
// first sample of a run, then compares every further sample against it.
// Optional build macro: BIST_MISR_EN adds a 16-bit MISR and the signature port.
// Ports:
//   clk            in  1      system clock, rising edge
//   rst            in  1      synchronous active-high reset
//   start          in  1      begin a run (accepted in IDLE/DONE only)
//   mode           in  2      pattern select, latched on accepted start
//   sample_valid   in  1      sample qualifier
//   sample         in  16     observed pattern word
//   busy           out 1      run in progress (SYNC/CHECK)
//   done           out 1      run finished (DONE)
//   pass           out 1      valid with done: no mismatches
//   err_count      out CNT_W  saturating mismatch count
//   first_err_idx  out IDX_W  index of first mismatch, all-ones if none
//   signature      out 16     MISR value (BIST_MISR_EN only)
module bist_response_checker
    import bist_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 64,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDX_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             sample_valid,
    input  logic [15:0]      sample,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx
`ifdef BIST_MISR_EN
    ,
    output logic [15:0]      signature
`endif
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [15:0]      exp_q, exp_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] first_q, first_d;
    logic             pass_q, pass_d;

    logic        start_ok;
    logic        accept;
    logic        last;
    logic        mismatch;
    logic [15:0] operand;
    logic [15:0] model_nxt;
    logic [15:0] model_seed;
    logic        sync_legal;

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign accept   = sample_valid && ((state_q == StSync) || (state_q == StCheck));
    assign last     = sample_valid && (state_q == StCheck) &&
                      (idx_q == IDX_W'(NUM_SAMPLES - 1));

    // In SYNC the model restarts from the sample itself if legal, else from the seed;
    // in CHECK it always advances from its own expectation.
    assign operand  = (state_q == StSync) ? (sync_legal ? sample : model_seed) : exp_q;
    assign mismatch = (state_q == StSync) ? !sync_legal : (sample != exp_q);

    bist_pattern_model u_model (
        .mode  (mode_q),
        .cur   (operand),
        .probe (sample),
        .nxt   (model_nxt),
        .seed  (model_seed),
        .legal (sync_legal)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StSync;
            StSync:  if (sample_valid) state_d = StCheck;
            StCheck: if (last) state_d = StDone;
            StDone:  if (start) state_d = StSync;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == StSync) || (state_q == StCheck);
        done = (state_q == StDone);
    end

    // Datapath next state
    always_comb begin
        mode_d  = mode_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        if (start_ok) begin
            mode_d  = mode_e'(mode);
            idx_d   = '0;
            err_d   = '0;
            first_d = '1;
            pass_d  = 1'b0;
        end else if (accept) begin
            exp_d = model_nxt;
            idx_d = idx_q + IDX_W'(1);
            if (mismatch) begin
                if (err_q != '1) begin
                    err_d = err_q + CNT_W'(1);
                end
                // All-ones is the "no error yet" marker; idx never reaches it.
                if (first_q == '1) begin
                    first_d = idx_q;
                end
            end
            if (last) begin
                pass_d = (err_d == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_ZERO;
            exp_q   <= 16'h0000;
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= '1;
            pass_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

`ifdef BIST_MISR_EN
    logic [15:0] sig_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sig_q <= 16'h0000;
        end else if (accept) begin
            sig_q <= lfsr_step(sig_q) ^ sample;
        end
    end

    assign signature = sig_q;
`endif

endmodule

// File: tb/tb_bist_response_checker.sv
// tb_bist_response_checker: directed stimulus for bist_response_checker with a
// behavioural scoreboard compared on every falling clock edge, plus literal
// expectations at the end of each run. Build with BIST_MISR_EN to cover the MISR.
module tb_bist_response_checker;

    localparam int N = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = 16'h0000;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] first_err_idx;
`ifdef BIST_MISR_EN
    logic [15:0] signature;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    bist_response_checker #(
        .NUM_SAMPLES (N),
        .CNT_W       (8),
        .IDX_W       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
`ifdef BIST_MISR_EN
        ,
        .signature     (signature)
`endif
    );

    // ---------------- reference sequence rules ----------------
    function automatic logic [15:0] f_next(input logic [1:0] m, input logic [15:0] e);
        logic [15:0] r;
        case (m)
            2'd1:    r = (e << 1) | (e >> 15);
            2'd2:    r = (e << 1) | {15'd0, ~e[15]};
            2'd3:    r = (e << 1) | {15'd0, e[15] ^ e[13] ^ e[12] ^ e[10]};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    function automatic bit f_legal(input logic [1:0] m, input logic [15:0] s);
        case (m)
            2'd0:    return s == 16'h0000;
            2'd1:    return $countones(s) == 1;
            2'd3:    return s != 16'h0000;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] f_seed(input logic [1:0] m);
        case (m)
            2'd1:    return 16'h0001;
            2'd3:    return 16'hACE1;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural scoreboard ----------------
    bit          m_busy = 0, m_done = 0, m_synced = 0, m_pass = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [15:0] m_exp = 16'h0000, m_sig = 16'h0000;
    int          m_idx = 0, m_errs = 0, m_first = -1;
    logic        m_bad;
    logic [15:0] m_base;

    assign m_bad  = !m_synced ? !f_legal(m_mode, sample) : (sample != m_exp);
    assign m_base = !m_synced ? (f_legal(m_mode, sample) ? sample : f_seed(m_mode)) : m_exp;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_synced <= 0; m_pass <= 0;
            m_errs <= 0; m_first <= -1; m_idx <= 0; m_sig <= 16'h0000;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1; m_done <= 0; m_synced <= 0; m_pass <= 0; m_mode <= mode;
                m_errs <= 0; m_first <= -1; m_idx <= 0; m_sig <= 16'h0000;
            end
        end else if (sample_valid) begin
            m_synced <= 1;
            m_exp    <= f_next(m_mode, m_base);
            m_sig    <= f_next(2'd3, m_sig) ^ sample;
            m_idx    <= m_idx + 1;
            if (m_bad) begin
                m_errs <= m_errs + 1;
                if (m_first < 0) m_first <= m_idx;
            end
            if (m_idx == N - 1) begin
                m_busy <= 0;
                m_done <= 1;
                m_pass <= (m_errs + (m_bad ? 1 : 0)) == 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("err_count", 32'(err_count), (m_errs > 255) ? 32'd255 : 32'(m_errs));
            chk("first_err_idx", 32'(first_err_idx),
                (m_first < 0) ? 32'h0000_FFFF : 32'(m_first));
`ifdef BIST_MISR_EN
            chk("signature", 32'(signature), 32'(m_sig));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full run: s0 is the sync sample, s1 the next, then the mode's sequence.
    // err_at = sample index to corrupt with err_x, -2 corrupts every sample.
    task automatic run(input logic [1:0] m, input logic [15:0] s0, input logic [15:0] s1,
                       input int gap, input int err_at, input logic [15:0] err_x,
                       input int busy_start_at, input string nm);
        logic [15:0] v;
        start = 1'b1; mode = m; sample_valid = 1'b0;
        step();
        start = 1'b0; mode = ~m;
        v = s0;
        for (int i = 0; i < N; i++) begin
            if (i == 1) v = s1;
            else if (i > 1) v = f_next(m, v);
            sample_valid = 1'b1;
            sample = ((i == err_at) || (err_at == -2)) ? (v ^ err_x) : v;
            start = (i == busy_start_at);
            step();
            start = 1'b0;
            for (int g = 0; g < gap; g++) begin
                sample_valid = 1'b0;
                sample = 16'($urandom);
                step();
            end
        end
        sample_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_done_timing"}, 32'(done), 32'd1);
        // Samples arriving after DONE must not disturb the result.
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample = 16'($urandom);
            step();
        end
        sample_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_first", 32'(first_err_idx), 32'hFFFF);
`ifdef BIST_MISR_EN
        chk("rst_sig", 32'(signature), 32'd0);
`endif

        // Pin the scoreboard's sequence rules to hand-computed values.
        chk("pin_lfsr", 32'(f_next(2'd3, 16'hACE1)), 32'h59C3);
        chk("pin_ring", 32'(f_next(2'd1, 16'h8000)), 32'h0001);
        chk("pin_john", 32'(f_next(2'd2, 16'h00FF)), 32'h01FF);

        // Ring, clean, with an ignored start mid-run.
        step();
        run(2'd1, 16'h0001, 16'h0002, 0, -1, 16'h0000, 100, "ring");
        chk("ring_pass", 32'(pass), 32'd1);
        chk("ring_err", 32'(err_count), 32'd0);
        chk("ring_first", 32'(first_err_idx), 32'hFFFF);

        // LFSR with one corrupted sample at index 10.
        run(2'd3, 16'hACE1, 16'h59C3, 0, 10, 16'h0004, -1, "lfsr");
        chk("lfsr_pass", 32'(pass), 32'd0);
        chk("lfsr_err", 32'(err_count), 32'd1);
        chk("lfsr_first", 32'(first_err_idx), 32'd10);

        // Johnson, sync on 00FF, valid every other cycle.
        run(2'd2, 16'h00FF, 16'h01FF, 1, -1, 16'h0000, -1, "john");
        chk("john_pass", 32'(pass), 32'd1);
        chk("john_err", 32'(err_count), 32'd0);

        // Ring, illegal sync sample: model reseeds, stream continues from 0002.
        run(2'd1, 16'h0003, 16'h0002, 0, -1, 16'h0000, -1, "ringbad");
        chk("ringbad_pass", 32'(pass), 32'd0);
        chk("ringbad_err", 32'(err_count), 32'd1);
        chk("ringbad_first", 32'(first_err_idx), 32'd0);

        // Zero mode, every sample FFFF: counter saturates.
        run(2'd0, 16'h0000, 16'h0000, 0, -2, 16'hFFFF, -1, "zero");
        chk("zero_err", 32'(err_count), 32'd255);
        chk("zero_first", 32'(first_err_idx), 32'd0);
        chk("zero_pass", 32'(pass), 32'd0);

        // Abort mid-CHECK with rst (start asserted alongside: rst wins).
        start = 1'b1; mode = 2'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'b1;
            sample = (i == 5) ? 16'h1234 : f_next(2'd1, 16'h8000) << i;
            step();
        end
        rst = 1'b1; start = 1'b1; sample_valid = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; sample_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_err", 32'(err_count), 32'd0);
        chk("abort_first", 32'(first_err_idx), 32'hFFFF);

        // Clean run after the abort.
        step();
        run(2'd1, 16'h0001, 16'h0002, 0, -1, 16'h0000, -1, "ring2");
        chk("ring2_pass", 32'(pass), 32'd1);
        chk("ring2_err", 32'(err_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
